// File: rtl/alu_iter.sv
// alu_iter: registered EX-stage ALU with valid/ready operand and result handshakes.
// Define ALU_ITER_MULDIV_EN for iterative mul/mulhu/divu/remu; otherwise codes 11-14 return 0 in one cycle.
module alu_iter #(
    parameter int WIDTH = 32,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUCode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DONE = 2'd3;
    logic [1:0] state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, single;
    logic [SHW-1:0] shamt;
    logic accept;

    assign shamt = B[SHW-1:0];
    assign in_ready = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    assign accept = in_valid && in_ready;
    assign out_valid = state_q == S_DONE;
    assign ALUResult = res_q;

    // Codes 11-15 fall to zero here; the iterative unit supplies 11-14 when present.
    always_comb begin
        case (ALUCode)
            4'd0:    single = A + B;
            4'd1:    single = A - B;
            4'd2:    single = B;
            4'd3:    single = A & B;
            4'd4:    single = A ^ B;
            4'd5:    single = A | B;
            4'd6:    single = A << shamt;
            4'd7:    single = A >> shamt;
            4'd8:    single = WIDTH'($signed(A) >>> shamt);
            4'd9:    single = WIDTH'($signed(A) < $signed(B));
            4'd10:   single = WIDTH'(A < B);
            default: single = '0;
        endcase
    end

`ifdef ALU_ITER_MULDIV_EN
    localparam logic [1:0] S_MUL = 2'd1;
    localparam logic [1:0] S_DIV = 2'd2;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [WIDTH:0] msum, rsh, diff;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic hsel_q, hsel_d, is_mul, is_div;

    assign is_mul = ALUCode == 4'd11 || ALUCode == 4'd12;
    assign is_div = ALUCode == 4'd13 || ALUCode == 4'd14;
    assign busy = state_q == S_MUL || state_q == S_DIV;
    // Mul: {hi,lo} is partial product over the shifting multiplier. Div: hi is remainder, lo shifts dividend out and quotient in.
    assign msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign rsh = {hi_q, lo_q[WIDTH-1]};
    assign diff = rsh - {1'b0, opnd_q};

    always_comb begin
        state_d = state_q;
        res_d = res_q;
        hi_d = hi_q;
        lo_d = lo_q;
        opnd_d = opnd_q;
        cnt_d = cnt_q;
        hsel_d = hsel_q;
        if (state_q == S_MUL) begin
            hi_d = msum[WIDTH:1];
            lo_d = {msum[0], lo_q[WIDTH-1:1]};
            cnt_d = cnt_q + SHW'(1);
        end
        if (state_q == S_DIV) begin
            hi_d = diff[WIDTH] ? rsh[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_d = cnt_q + SHW'(1);
        end
        if (busy && &cnt_q) begin
            state_d = S_DONE;
            res_d = hsel_q ? hi_d : lo_d;
        end
        if (state_q == S_DIV && opnd_q == '0) begin
            state_d = S_DONE;
            res_d = hsel_q ? lo_q : '1;
        end
        if (state_q == S_DONE && out_ready) state_d = S_IDLE;
        if (accept) begin
            state_d = is_mul ? S_MUL : is_div ? S_DIV : S_DONE;
            res_d = (is_mul || is_div) ? res_q : single;
            hi_d = '0;
            lo_d = A;
            opnd_d = B;
            cnt_d = '0;
            hsel_d = ALUCode == 4'd12 || ALUCode == 4'd14;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            res_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            opnd_q <= '0;
            cnt_q <= '0;
            hsel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q <= res_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            opnd_q <= opnd_d;
            cnt_q <= cnt_d;
            hsel_q <= hsel_d;
        end
    end
`else
    assign busy = 1'b0;

    always_comb begin
        state_d = state_q;
        res_d = res_q;
        if (state_q == S_DONE && out_ready) state_d = S_IDLE;
        if (accept) begin
            state_d = S_DONE;
            res_d = single;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            res_q <= '0;
        end else begin
            state_q <= state_d;
            res_q <= res_d;
        end
    end
`endif
endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, registered ALU for the EX stage.
- Supports the base 4-bit ALUCode op set plus shifts and iterative unsigned multiply/divide.
- Operands enter through a valid/ready handshake; results leave through a valid/ready handshake.
- Multi-cycle ops stall the issuing stage via in_ready.

Parameters:
- WIDTH, 32: operand/result width; power of two, 8..64.
- SHW, $clog2(WIDTH): shift-amount width, derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands and op presented
- in_ready  output  1  block accepts an op this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- ALUCode  input  4  operation select
- out_valid  output  1  ALUResult valid
- out_ready  input  1  consumer accepts result
- ALUResult  output  WIDTH  registered result
- busy  output  1  multi-cycle op in progress

Behaviour:
- Accept: in_valid && in_ready at a rising edge captures A, B and ALUCode.
- Op map (result width WIDTH, wrap-around modulo 2^WIDTH):
  - 0 add: A+B. 1 sub: A-B. 2 pass B. 3 A&B. 4 A^B. 5 A|B.
  - 6 sll: A<<B[SHW-1:0]. 7 srl: logical A>>B[SHW-1:0]. 8 sra: arithmetic A>>>B[SHW-1:0].
  - 9 slt: signed A<B, result 1/0. 10 sltu: unsigned A<B, result 1/0.
  - 11 mul: low WIDTH bits of A*B. 12 mulhu: high WIDTH bits of unsigned A*B.
  - 13 divu: unsigned A/B. 14 remu: unsigned A%B. 15: result 0.
- Overflow: slt/sltu use the full comparison; the sign of the wrapped difference alone is not sufficient.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - in_ready=1.
  - Single-cycle op accepted -> ALUResult registered at the same edge -> DONE. out_valid=1 the next cycle (latency 1).
  - Op 11/12 -> MUL. Op 13/14 -> DIV.
- MUL: radix-2 shift-add, one bit per cycle, WIDTH iterations -> DONE. Latency from accept to out_valid: WIDTH+1 cycles.
- DIV:
  - Restoring division, one bit per cycle, WIDTH iterations -> DONE. Latency WIDTH+1.
  - B==0: no iteration; DONE after 1 cycle. divu result all-ones; remu result A.
- DONE:
  - out_valid=1.
  - ALUResult holds stable until out_ready=1.
  - On out_valid && out_ready: -> IDLE.
  - in_ready=out_ready in DONE, so back-to-back ops are allowed. A new accept in the same cycle follows the IDLE rules.
- busy=1 only in MUL/DIV. in_ready=0 in MUL/DIV; in_valid is ignored there.
- Reset (any state, including mid-iteration):
  - state=IDLE, ALUResult=0, out_valid=0, busy=0.
  - Internal accumulators cleared; partial results are discarded.
  - in_ready is 1 the cycle after reset deasserts.
- Operands are captured at accept; input changes after accept do not affect the result.

Optional Feature:
- Macro ALU_ITER_MULDIV_EN.
- Defined: MUL/DIV states and datapath present, as above.
- Undefined:
  - No MUL/DIV logic; busy tied 0.
  - Codes 11-14 behave as single-cycle ops with result 0.
  - All ops have latency 1.

Test Plan:
- WIDTH=32, reset held 2 cycles mid-MUL (A=3,B=5, reset at iteration 10) -> ALUResult=0, out_valid=0, busy=0. First accept after release completes normally.
- add 0xFFFFFFFF+1 -> 0x00000000. sub 0x00000000-1 -> 0xFFFFFFFF. slt 0x80000000,1 -> 1. sltu 0x80000000,1 -> 0. Each out_valid exactly 1 cycle after accept with out_ready=1.
- sra A=0x80000000,B=0x24 (shamt 4) -> 0xF8000000. srl same -> 0x08000000. sll A=1,B=31 -> 0x80000000.
- mul 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001. mulhu same operands -> 0xFFFFFFFE. out_valid 33 cycles after accept; busy=1 for 32 cycles; in_ready=0 throughout.
- divu 100/7 -> 14. remu 100/7 -> 2. divu 5/0 -> 0xFFFFFFFF. remu 5/0 -> 5. Divide-by-zero out_valid 2 cycles after accept.
- Backpressure: add result with out_ready=0 for 5 cycles -> ALUResult stable, in_ready=0. out_ready=1 with new in_valid the same cycle -> second op accepted, result 1 cycle later.
